// File: rtl/fu_csr_wq.sv
// rtl/fu_csr_wq.sv - CSR functional unit with an in-order pending CSR write queue
// Macro CSR_WQ_FWD_EN: forwarding from pending writes; when undefined CSR ops serialise on an empty queue.
package fu_csr_wq_pkg;
  localparam int XLEN = 32;
  localparam int ID_W = 6;

  typedef enum logic [3:0] {
    OP_NOP, CSR_WRITE, CSR_SET, CSR_CLEAR, CSR_READ,
    FENCE, ECALL, EBREAK, XRET, WFI, FENCE_I, FENCE_VMA
  } op_t;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [XLEN-1:0] pc;
    logic [4:0]      prd;
    op_t             op;
    logic [11:0]     imm;
    logic [XLEN-1:0] rs1val;
  } fu_input_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ID_W-1:0] id;
    logic [4:0]      prd;
    logic [XLEN-1:0] rdval;
  } fu_output_t;

  typedef struct packed {
    logic [ID_W-1:0] id;
  } rob_entry_t;
endpackage

interface csr_if;
  logic                            rvalid;
  logic [11:0]                     raddr;
  logic [fu_csr_wq_pkg::XLEN-1:0]  rdata;
  logic                            wvalid;
  logic [11:0]                     waddr;
  logic [fu_csr_wq_pkg::XLEN-1:0]  wdata;
  modport master (output rvalid, raddr, wvalid, waddr, wdata, input rdata);
  modport slave  (input rvalid, raddr, wvalid, waddr, wdata, output rdata);
endinterface

interface squash_if;
  logic valid;
  modport master (output valid);
  modport slave  (input valid);
endinterface

module fu_csr_wq
  import fu_csr_wq_pkg::*;
#(
  parameter int CSRQ_DEPTH = 4,
  parameter int CNT_W      = $clog2(CSRQ_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  fu_input_t        fuinput_i,
  input  logic             fuinput_i_valid,
  output logic             fuinput_i_ready,
  output fu_output_t       fuoutput_o,
  output logic             fuoutput_o_valid,
  output logic             completion_o_valid,
  input  rob_entry_t       retire_entry_i,
  input  logic             retire_entry_i_valid,
  csr_if.master            csr_io,
  squash_if.slave          squash_io,
  output logic [CNT_W-1:0] csrq_count_o
);
  localparam int PTR_W = $clog2(CSRQ_DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(CSRQ_DEPTH);

  logic [ID_W-1:0]  q_id   [CSRQ_DEPTH];
  logic [11:0]      q_addr [CSRQ_DEPTH];
  logic [XLEN-1:0]  q_data [CSRQ_DEPTH];
  logic [PTR_W-1:0] head, tail;
  logic [CNT_W-1:0] count;
  logic             is_csr, need_write, ready, enq, pop;
  logic [XLEN-1:0]  old_val, new_val;
  logic [11:0]      raddr;

  assign raddr = fuinput_i.imm;

  always_comb begin
    is_csr     = 1'b0;
    need_write = 1'b0;
    case (fuinput_i.op)
      CSR_WRITE, CSR_SET, CSR_CLEAR: begin
        is_csr     = 1'b1;
        need_write = 1'b1;
      end
      CSR_READ: is_csr = 1'b1;
      default: ;
    endcase
  end

`ifdef CSR_WQ_FWD_EN
  logic [PTR_W-1:0] fwd_idx;
  always_comb begin
    old_val = csr_io.rdata;
    fwd_idx = head;
    // Walk oldest to youngest in age order so the last hit is the youngest matching write.
    for (int k = 0; k < CSRQ_DEPTH; k++) begin
      fwd_idx = head + PTR_W'(k);
      if ((CNT_W'(k) < count) && (q_addr[fwd_idx] == raddr)) old_val = q_data[fwd_idx];
    end
  end
  assign ready = (count < DEPTH_C);
`else
  assign old_val = csr_io.rdata;
  assign ready   = is_csr ? (count == '0) : (count < DEPTH_C);
`endif

  always_comb begin
    case (fuinput_i.op)
      CSR_WRITE: new_val = fuinput_i.rs1val;
      CSR_SET:   new_val = old_val | fuinput_i.rs1val;
      CSR_CLEAR: new_val = old_val & ~fuinput_i.rs1val;
      default:   new_val = old_val;
    endcase
  end

  assign enq = fuinput_i_valid & ready & need_write;
  assign pop = retire_entry_i_valid & (count != '0) & (q_id[head] == retire_entry_i.id);

  assign csr_io.rvalid = fuinput_i_valid & is_csr;
  assign csr_io.raddr  = raddr;
  assign csr_io.wvalid = pop;
  assign csr_io.waddr  = q_addr[head];
  assign csr_io.wdata  = q_data[head];

  assign fuinput_i_ready    = ready;
  assign fuoutput_o.pc      = fuinput_i.pc;
  assign fuoutput_o.id      = fuinput_i.id;
  assign fuoutput_o.prd     = fuinput_i.prd;
  assign fuoutput_o.rdval   = is_csr ? old_val : '0;
  assign fuoutput_o_valid   = fuinput_i_valid & ready & is_csr;
  assign completion_o_valid = fuinput_i_valid & ready;
  assign csrq_count_o       = count;

  // Squash drops every pending write; a same-cycle pop has already committed via wvalid.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (squash_io.valid) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq) tail <= tail + PTR_W'(1);
      if (pop) head <= head + PTR_W'(1);
      case ({enq, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      q_id[tail]   <= fuinput_i.id;
      q_addr[tail] <= raddr;
      q_data[tail] <= new_val;
    end
  end
endmodule
